// File: rtl/hpi_target_if.sv
// HPI bus between the host-side initiator and the hpi_target responder.
interface hpi_target_if;
  logic        hpi_cs_n;
  logic        hpi_rd_n;
  logic        hpi_wr_n;
  logic        hpi_rst_n;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_din;
  logic [15:0] hpi_dout;
  logic        hpi_doe;

  modport master (
    output hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n, hpi_addr, hpi_din,
    input  hpi_dout, hpi_doe
  );

  modport slave (
    input  hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n, hpi_addr, hpi_din,
    output hpi_dout, hpi_doe
  );
endinterface

// File: rtl/hpi_target.sv
// CY7C67200 HPI responder: DATA/MAILBOX/ADDRESS/STATUS registers in front of a
// word RAM with an auto-incrementing byte pointer and a two-way mailbox.
module hpi_target #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  hpi_target_if.slave   hpi,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [15:0]   loc_wdata,
  output logic [15:0]   loc_rdata,
  output logic          loc_collide,
  output logic [15:0]   mbx_in_data,
  output logic          mbx_in_full,
  input  logic          mbx_in_ack,
  input  logic          mbx_out_wr,
  input  logic [15:0]   mbx_out_data,
  output logic          proto_err
);
  localparam logic [1:0] RegData = 2'd0;
  localparam logic [1:0] RegMbx  = 2'd1;
  localparam logic [1:0] RegAddr = 2'd2;
  localparam logic [1:0] RegStat = 2'd3;

  logic [15:0]   ram_q [DEPTH];
  logic [15:0]   ptr_q, ptr_d;
  logic [15:0]   mbx_out_q, mbx_in_data_q, dout_q, loc_rdata_q, rd_word;
  logic          mbx_out_full_q, mbx_in_full_q, proto_err_q, doe_q, collide_q;
  logic          rd_prev_q, wr_prev_q;  // strobe was asserted last cycle
  logic [1:0]    rd_sel_q, rd_sel;
  logic          soft_rst, cs, rd, wr, err;
  logic          rd_fall, rd_rise, wr_fall, doe_d;
  logic          wr_data, wr_mbx, wr_addr, host_we, collide;
  logic          rd_data_rise, rd_mbx_rise;
  logic [AW-1:0] host_idx;

  assign soft_rst = Reset | ~hpi.hpi_rst_n;
  assign cs       = ~hpi.hpi_cs_n;
  assign rd       = ~hpi.hpi_rd_n;
  assign wr       = ~hpi.hpi_wr_n;
  assign err      = cs & rd & wr;

  assign rd_fall  = cs & rd & ~rd_prev_q & ~err;
  assign wr_fall  = cs & wr & ~wr_prev_q & ~err;
  // A rise only counts when it closes a read that was actually open.
  assign rd_rise  = rd_prev_q & ~rd & doe_q;
  assign doe_d    = cs & rd & ~err & (rd_fall | doe_q);

  assign wr_data  = wr_fall & (hpi.hpi_addr == RegData);
  assign wr_mbx   = wr_fall & (hpi.hpi_addr == RegMbx);
  assign wr_addr  = wr_fall & (hpi.hpi_addr == RegAddr);
  assign host_idx = ptr_q[AW:1];
  assign host_we  = wr_data & ~soft_rst;
  assign collide  = loc_we & host_we & (loc_addr == host_idx);

  assign rd_sel       = rd_fall ? hpi.hpi_addr : rd_sel_q;
  assign rd_data_rise = rd_rise & (rd_sel_q == RegData);
  assign rd_mbx_rise  = rd_rise & (rd_sel_q == RegMbx);

  assign hpi.hpi_dout = dout_q;
  assign hpi.hpi_doe  = doe_q;
  assign loc_rdata    = loc_rdata_q;
  assign loc_collide  = collide_q;
  assign mbx_in_data  = mbx_in_data_q;
  assign mbx_in_full  = mbx_in_full_q;
  assign proto_err    = proto_err_q;

  // Word presented to the host for the register being read.
  always_comb begin
    rd_word = 16'h0000;
    case (rd_sel)
      RegData: rd_word = ram_q[host_idx];
      RegMbx:  rd_word = mbx_out_q;
      RegAddr: rd_word = ptr_q;
      RegStat: rd_word = {13'd0, proto_err_q, mbx_in_full_q, mbx_out_full_q};
      default: rd_word = 16'h0000;
    endcase
  end

  // Byte pointer: ADDRESS load, or step by one word per DATA write / DATA read.
  always_comb begin
    ptr_d = ptr_q;
    if (wr_addr) begin
      ptr_d = {hpi.hpi_din[15:1], 1'b0};
    end else begin
      if (wr_data)      ptr_d = ptr_d + 16'd2;
      if (rd_data_rise) ptr_d = ptr_d + 16'd2;
    end
  end

  // Dual-port RAM; host wins a same-index collision. Not cleared by reset.
  always_ff @(posedge Clk) begin
    if (host_we) ram_q[host_idx] <= hpi.hpi_din;
    if (loc_we && !collide) ram_q[loc_addr] <= loc_wdata;
    loc_rdata_q <= ram_q[loc_addr];
  end

  // Register file, mailbox, strobe history and host read path.
  always_ff @(posedge Clk) begin
    if (soft_rst) begin
      ptr_q          <= 16'h0000;
      mbx_in_data_q  <= 16'h0000;
      mbx_in_full_q  <= 1'b0;
      mbx_out_q      <= 16'h0000;
      mbx_out_full_q <= 1'b0;
      proto_err_q    <= 1'b0;
      doe_q          <= 1'b0;
      dout_q         <= 16'h0000;
      collide_q      <= 1'b0;
      rd_prev_q      <= 1'b0;
      wr_prev_q      <= 1'b0;
      rd_sel_q       <= RegData;
    end else begin
      rd_prev_q <= rd;
      wr_prev_q <= wr;
      ptr_q     <= ptr_d;
      doe_q     <= doe_d;
      collide_q <= collide;
      if (rd_fall) rd_sel_q <= hpi.hpi_addr;
      if (doe_d)   dout_q   <= rd_word;
      if (err)     proto_err_q <= 1'b1;
      if (wr_mbx) begin
        mbx_in_data_q <= hpi.hpi_din;
        mbx_in_full_q <= 1'b1;
      end else if (mbx_in_ack) begin
        mbx_in_full_q <= 1'b0;
      end
      if (mbx_out_wr) begin
        mbx_out_q      <= mbx_out_data;
        mbx_out_full_q <= 1'b1;
      end else if (rd_mbx_rise) begin
        mbx_out_full_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hpi_target.sv
// Self-checking bench for hpi_target: a vector table for plain register
// traffic plus hand-written sequences for the multi-cycle corner cases.
module tb_hpi_target;
  localparam logic [1:0] AData = 2'd0;
  localparam logic [1:0] AMbx  = 2'd1;
  localparam logic [1:0] AAddr = 2'd2;
  localparam logic [1:0] AStat = 2'd3;
  localparam int NV = 10;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] data;  // write data, or expected read data
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        loc_we, loc_collide, mbx_in_full, mbx_in_ack, mbx_out_wr, proto_err;
  logic [7:0]  loc_addr;
  logic [15:0] loc_wdata, loc_rdata, mbx_in_data, mbx_out_data;

  int          n_vec = 0;
  int          n_miss = 0;
  logic [15:0] exp_q[$];
  vec_t        tbl [NV];
  logic [15:0] got;

  always #10 Clk = ~Clk;

  hpi_target_if bus();

  hpi_target #(.DEPTH(256), .AW(8)) dut (
    .Clk(Clk), .Reset(Reset), .hpi(bus),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata), .loc_collide(loc_collide),
    .mbx_in_data(mbx_in_data), .mbx_in_full(mbx_in_full), .mbx_in_ack(mbx_in_ack),
    .mbx_out_wr(mbx_out_wr), .mbx_out_data(mbx_out_data), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] addr, input logic [15:0] data);
    bus.hpi_addr = addr;
    bus.hpi_din  = data;
    bus.hpi_cs_n = 1'b0;
    bus.hpi_wr_n = 1'b0;
    tick();
    bus.hpi_wr_n = 1'b1;
    bus.hpi_cs_n = 1'b1;
    tick();
  endtask

  // Expected value goes on the scoreboard when the strobe is driven and is
  // retired when the target presents its word.
  task automatic host_read(input logic [1:0] addr, input logic [15:0] exp, input string name);
    logic [15:0] word;
    exp_q.push_back(exp);
    bus.hpi_addr = addr;
    bus.hpi_cs_n = 1'b0;
    bus.hpi_rd_n = 1'b0;
    tick();
    chk({name, " doe"}, {15'd0, bus.hpi_doe}, 16'd1);
    word = bus.hpi_dout;
    bus.hpi_rd_n = 1'b1;
    bus.hpi_cs_n = 1'b1;
    tick();
    chk(name, word, exp_q.pop_front());
  endtask

  task automatic loc_write(input logic [7:0] addr, input logic [15:0] data);
    loc_we    = 1'b1;
    loc_addr  = addr;
    loc_wdata = data;
    tick();
    loc_we = 1'b0;
  endtask

  task automatic loc_read(input logic [7:0] addr, input logic [15:0] exp, input string name);
    loc_we   = 1'b0;
    loc_addr = addr;
    tick();
    chk(name, loc_rdata, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish, %0d miscompares so far", n_miss);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, AAddr, 16'h1000};
    tbl[1] = '{1'b1, AData, 16'hA5A5};
    tbl[2] = '{1'b1, AData, 16'h5A5A};
    tbl[3] = '{1'b1, AAddr, 16'h1000};
    tbl[4] = '{1'b0, AData, 16'hA5A5};
    tbl[5] = '{1'b0, AData, 16'h5A5A};
    tbl[6] = '{1'b0, AAddr, 16'h1004};
    tbl[7] = '{1'b0, AStat, 16'h0000};
    tbl[8] = '{1'b1, AMbx,  16'hCE00};
    tbl[9] = '{1'b0, AStat, 16'h0002};

    Reset = 1'b1;
    bus.hpi_cs_n = 1'b1; bus.hpi_rd_n = 1'b1; bus.hpi_wr_n = 1'b1; bus.hpi_rst_n = 1'b1;
    bus.hpi_addr = 2'd0; bus.hpi_din = 16'h0000;
    loc_we = 1'b0; loc_addr = 8'd0; loc_wdata = 16'h0000;
    mbx_in_ack = 1'b0; mbx_out_wr = 1'b0; mbx_out_data = 16'h0000;
    tick();
    tick();
    Reset = 1'b0;
    chk("rst doe", {15'd0, bus.hpi_doe}, 16'd0);
    chk("rst dout", bus.hpi_dout, 16'h0000);
    chk("rst proto_err", {15'd0, proto_err}, 16'd0);
    chk("rst mbx_in_full", {15'd0, mbx_in_full}, 16'd0);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) host_write(tbl[i].addr, tbl[i].data);
      else host_read(tbl[i].addr, tbl[i].data, $sformatf("vec%0d", i));
    end
    chk("mbx_in_full", {15'd0, mbx_in_full}, 16'd1);
    chk("mbx_in_data", mbx_in_data, 16'hCE00);
    mbx_in_ack = 1'b1;
    tick();
    mbx_in_ack = 1'b0;
    host_read(AStat, 16'h0000, "stat after ack");

    // Host mailbox write in the same cycle as the ack: write wins.
    bus.hpi_addr = AMbx; bus.hpi_din = 16'hBEEF;
    bus.hpi_cs_n = 1'b0; bus.hpi_wr_n = 1'b0; mbx_in_ack = 1'b1;
    tick();
    bus.hpi_cs_n = 1'b1; bus.hpi_wr_n = 1'b1; mbx_in_ack = 1'b0;
    tick();
    chk("mbx wr+ack full", {15'd0, mbx_in_full}, 16'd1);
    chk("mbx wr+ack data", mbx_in_data, 16'hBEEF);
    mbx_in_ack = 1'b1;
    tick();
    mbx_in_ack = 1'b0;

    // Local keycode, then host read with output-enable timing.
    loc_write(8'd3, 16'h0029);
    host_write(AAddr, 16'h0006);
    bus.hpi_addr = AData; bus.hpi_cs_n = 1'b0; bus.hpi_rd_n = 1'b0;
    #1;
    chk("doe before fall", {15'd0, bus.hpi_doe}, 16'd0);
    tick();
    chk("doe after fall", {15'd0, bus.hpi_doe}, 16'd1);
    chk("key read", bus.hpi_dout, 16'h0029);
    tick();
    chk("doe held", {15'd0, bus.hpi_doe}, 16'd1);
    bus.hpi_rd_n = 1'b1; bus.hpi_cs_n = 1'b1;
    #1;
    chk("doe in rise cycle", {15'd0, bus.hpi_doe}, 16'd1);
    tick();
    chk("doe after rise", {15'd0, bus.hpi_doe}, 16'd0);
    loc_read(8'd3, 16'h0029, "loc key");
    host_read(AAddr, 16'h0008, "ptr after key");

    // Outbound mailbox.
    mbx_out_wr = 1'b1; mbx_out_data = 16'h0FED;
    tick();
    mbx_out_wr = 1'b0;
    host_read(AStat, 16'h0001, "stat out full");
    host_read(AMbx, 16'h0FED, "mbx out");
    host_read(AStat, 16'h0000, "stat out empty");
    mbx_out_wr = 1'b1; mbx_out_data = 16'h1234;
    tick();
    mbx_out_wr = 1'b0;
    bus.hpi_addr = AMbx; bus.hpi_cs_n = 1'b0; bus.hpi_rd_n = 1'b0;
    tick();
    got = bus.hpi_dout;
    chk("mbx out 2", got, 16'h1234);
    bus.hpi_rd_n = 1'b1; bus.hpi_cs_n = 1'b1;
    mbx_out_wr = 1'b1; mbx_out_data = 16'h4321;
    tick();
    mbx_out_wr = 1'b0;
    host_read(AStat, 16'h0001, "post beats rise");
    host_read(AMbx, 16'h4321, "mbx out 3");

    // RAM aliasing at the top of the pointer range.
    host_write(AAddr, 16'h01FE);
    host_write(AData, 16'h1111);
    host_write(AData, 16'h2222);
    host_read(AAddr, 16'h0202, "ptr after wrap");
    loc_read(8'd255, 16'h1111, "ram255");
    loc_read(8'd0, 16'h2222, "ram0 alias");

    // Same-index collision: host wins, one-cycle pulse.
    host_write(AAddr, 16'h000A);
    bus.hpi_addr = AData; bus.hpi_din = 16'h5555;
    bus.hpi_cs_n = 1'b0; bus.hpi_wr_n = 1'b0;
    loc_we = 1'b1; loc_addr = 8'd5; loc_wdata = 16'h6666;
    tick();
    chk("collide pulse", {15'd0, loc_collide}, 16'd1);
    bus.hpi_cs_n = 1'b1; bus.hpi_wr_n = 1'b1; loc_we = 1'b0;
    tick();
    chk("collide one cycle", {15'd0, loc_collide}, 16'd0);
    chk("collide host kept", loc_rdata, 16'h5555);
    // Different indices write in parallel.
    bus.hpi_din = 16'h6060; bus.hpi_cs_n = 1'b0; bus.hpi_wr_n = 1'b0;
    loc_we = 1'b1; loc_addr = 8'd7; loc_wdata = 16'h7777;
    tick();
    chk("no collide", {15'd0, loc_collide}, 16'd0);
    bus.hpi_cs_n = 1'b1; bus.hpi_wr_n = 1'b1; loc_we = 1'b0;
    tick();
    loc_read(8'd6, 16'h6060, "parallel host");
    loc_read(8'd7, 16'h7777, "parallel loc");

    // cs, rd and wr all low: sticky error, nothing commits.
    loc_write(8'd8, 16'h0808);
    host_write(AAddr, 16'h0010);
    bus.hpi_addr = AData; bus.hpi_din = 16'hDEAD;
    bus.hpi_cs_n = 1'b0; bus.hpi_rd_n = 1'b0; bus.hpi_wr_n = 1'b0;
    tick();
    chk("proto_err set", {15'd0, proto_err}, 16'd1);
    chk("proto doe", {15'd0, bus.hpi_doe}, 16'd0);
    bus.hpi_cs_n = 1'b1; bus.hpi_rd_n = 1'b1; bus.hpi_wr_n = 1'b1;
    tick();
    loc_read(8'd8, 16'h0808, "proto ram");
    host_read(AAddr, 16'h0010, "proto ptr");
    host_read(AStat, 16'h0004, "proto stat");

    // HPI soft reset in the middle of a read.
    mbx_out_wr = 1'b1; mbx_out_data = 16'h0AAA;
    tick();
    mbx_out_wr = 1'b0;
    bus.hpi_addr = AData; bus.hpi_cs_n = 1'b0; bus.hpi_rd_n = 1'b0;
    tick();
    chk("pre-rst doe", {15'd0, bus.hpi_doe}, 16'd1);
    bus.hpi_rst_n = 1'b0;
    tick();
    chk("soft rst doe", {15'd0, bus.hpi_doe}, 16'd0);
    chk("soft rst dout", bus.hpi_dout, 16'h0000);
    bus.hpi_rst_n = 1'b1; bus.hpi_cs_n = 1'b1; bus.hpi_rd_n = 1'b1;
    tick();
    host_read(AStat, 16'h0000, "soft rst stat");
    host_read(AAddr, 16'h0000, "soft rst ptr");
    loc_read(8'd8, 16'h0808, "soft rst ram8");
    loc_read(8'd3, 16'h0029, "soft rst ram3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
